// File: rtl/ip_param_ctrl.sv
// Ping-pong control for the FC weight double buffer: tracks the fill, full and read
// state of both halves and sequences read addresses to the inner-product MAC array.
module ip_param_ctrl #(
    parameter int FW = 32,
    parameter int WL = 288,
    parameter int AW = 9
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          layer_start_i,
    input  logic [15:0]   num_vec_i,
    input  logic          wr_buf_done_i,
    output logic          wr_buf_sel_o,
    output logic          wr_ready_o,
    output logic [1:0]    param_buf_full_o,
    output logic [1:0]    param_buf_busy_o,
    output logic [AW-1:0] ip_buf_addr_o,
    input  logic          ip_ready_i,
    output logic          ip_param_valid_o,
    output logic          ip_last_o,
    output logic          ip_vec_done_o,
    output logic          layer_done_o,
    input  logic [FW-1:0] buf_rdata_i,
    output logic [FW-1:0] ip_param_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    localparam logic [AW-1:0] ADDR_LAST = AW'(WL - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_wr_sel;
    logic          r_rd_sel;
    logic          r_active;
    logic [1:0]    r_full;
    logic [1:0]    r_busy;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_vec_cnt;
    logic [15:0]   r_wr_cnt;
    logic [15:0]   r_num_vec;

    logic          w_start;
    logic          w_wr_accept;
    logic          w_rd_start;
    logic          w_beat;
    logic          w_addr_last;
    logic          w_rel;
    logic          w_layer_end;
    logic [15:0]   w_vec_cnt_inc;
    logic [1:0]    w_set_mask;
    logic [1:0]    w_clr_mask;
    logic [1:0]    w_full_nxt;

    // A start pulse during an active layer is dropped; a done pulse onto a full half is dropped.
    assign w_start       = layer_start_i & ~r_active;
    assign w_wr_accept   = r_active & wr_buf_done_i & ~r_full[r_wr_sel];
    assign w_rd_start    = (r_state == ST_IDLE) & r_active & r_full[r_rd_sel];
    assign w_beat        = (r_state == ST_RD) & ip_ready_i;
    assign w_addr_last   = (r_addr == ADDR_LAST);
    assign w_rel         = (r_state == ST_REL);
    assign w_vec_cnt_inc = r_vec_cnt + 16'd1;
    assign w_layer_end   = w_rel & (w_vec_cnt_inc == r_num_vec);

    // Set and release always target different halves, so both masks apply in one edge.
    assign w_set_mask = w_wr_accept ? (r_wr_sel ? 2'b10 : 2'b01) : 2'b00;
    assign w_clr_mask = w_rel       ? (r_rd_sel ? 2'b10 : 2'b01) : 2'b00;
    assign w_full_nxt = (r_full | w_set_mask) & ~w_clr_mask;

    assign wr_buf_sel_o     = r_wr_sel;
    assign wr_ready_o       = r_active & ~r_full[r_wr_sel] & (r_wr_cnt < r_num_vec);
    assign param_buf_full_o = r_full;
    assign param_buf_busy_o = r_busy;
    assign ip_buf_addr_o    = (r_busy != 2'b00) ? r_addr : {AW{1'b0}};
    assign ip_param_o       = buf_rdata_i;

    // Read FSM state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_rd_start ? ST_RD : ST_IDLE;
            ST_RD:   w_state_nxt = (w_beat & w_addr_last) ? ST_REL : ST_RD;
            ST_REL:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read FSM outputs; the buffer is read combinationally so valid tracks ready directly.
    always_comb begin
        ip_param_valid_o = 1'b0;
        ip_last_o        = 1'b0;
        ip_vec_done_o    = 1'b0;
        layer_done_o     = 1'b0;
        case (r_state)
            ST_RD: begin
                ip_param_valid_o = ip_ready_i;
                ip_last_o        = ip_ready_i & w_addr_last;
            end
            ST_REL: begin
                ip_vec_done_o = 1'b1;
                layer_done_o  = w_layer_end;
            end
            default: begin
                ip_param_valid_o = 1'b0;
                ip_last_o        = 1'b0;
            end
        endcase
    end

    // Half bookkeeping, layer counters and read address.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_active  <= 1'b0;
            r_full    <= 2'b00;
            r_busy    <= 2'b00;
            r_addr    <= {AW{1'b0}};
            r_vec_cnt <= 16'd0;
            r_wr_cnt  <= 16'd0;
            r_num_vec <= 16'd0;
        end else if (w_start) begin
            r_active  <= 1'b1;
            r_vec_cnt <= 16'd0;
            r_wr_cnt  <= 16'd0;
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_full    <= 2'b00;
            r_num_vec <= num_vec_i;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_accept) begin
                r_wr_sel <= ~r_wr_sel;
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            if (w_rd_start) begin
                r_busy[r_rd_sel] <= 1'b1;
                r_addr           <= {AW{1'b0}};
            end else if (w_beat & ~w_addr_last) begin
                r_addr <= r_addr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_rel) begin
                r_busy    <= 2'b00;
                r_rd_sel  <= ~r_rd_sel;
                r_vec_cnt <= w_vec_cnt_inc;
                if (w_layer_end) begin
                    r_active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ip_param_ctrl.sv
// Self-checking bench for ip_param_ctrl: a word-count model of the ping-pong buffer
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_ip_param_ctrl;

    localparam int FW = 32;
    localparam int WL = 288;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          ls = 1'b0;
    logic [15:0]   nv = 16'd0;
    logic          wd = 1'b0;
    logic          rdy = 1'b0;
    logic          wsel_o, wrdy_o, valid_o, last_o, vdone_o, ldone_o;
    logic [1:0]    full_o, busy_o;
    logic [AW-1:0] addr_o;
    logic [FW-1:0] rdata, param_o;

    ip_param_ctrl #(.FW(FW), .WL(WL), .AW(AW)) dut (
        .clk_i(clk), .rstn_i(rstn), .layer_start_i(ls), .num_vec_i(nv),
        .wr_buf_done_i(wd), .wr_buf_sel_o(wsel_o), .wr_ready_o(wrdy_o),
        .param_buf_full_o(full_o), .param_buf_busy_o(busy_o), .ip_buf_addr_o(addr_o),
        .ip_ready_i(rdy), .ip_param_valid_o(valid_o), .ip_last_o(last_o),
        .ip_vec_done_o(vdone_o), .layer_done_o(ldone_o),
        .buf_rdata_i(rdata), .ip_param_o(param_o)
    );

    always #5 clk = ~clk;

    // Buffer model: data word tagged with the address being read.
    assign rdata = {16'hBEEF, 7'd0, addr_o};

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Model: m_word = -1 waiting for a full half, 0..WL-1 next word to hand out, WL = release cycle.
    int       m_word = -1;
    bit       m_act = 1'b0;
    bit [1:0] m_full = 2'b00;
    bit       m_wsel = 1'b0;
    bit       m_rsel = 1'b0;
    int       m_vec = 0, m_wcnt = 0, m_nv = 0;

    int       cnt_valid = 0, cnt_vdone = 0, cnt_ldone = 0, cnt_both = 0, cnt_block = 0;
    logic [7:0] rd_hist = 8'd0;

    bit       e_valid, e_last, e_vdone, e_ldone, e_wrdy;
    bit [1:0] e_busy;

    always @(negedge clk) begin
        if (!rstn) begin
            chk("rst_valid", {31'd0, valid_o}, 32'd0);
            chk("rst_busy", {30'd0, busy_o}, 32'd0);
            chk("rst_full", {30'd0, full_o}, 32'd0);
            chk("rst_wrdy", {31'd0, wrdy_o}, 32'd0);
            chk("rst_addr", {23'd0, addr_o}, 32'd0);
            m_word = -1; m_act = 1'b0; m_full = 2'b00; m_wsel = 1'b0; m_rsel = 1'b0;
            m_vec = 0; m_wcnt = 0; m_nv = 0;
        end else begin
            e_valid = (m_word >= 0) && (m_word < WL) && rdy;
            e_last  = e_valid && (m_word == WL - 1);
            e_vdone = (m_word == WL);
            e_ldone = e_vdone && (m_vec + 1 == m_nv);
            e_busy  = (m_word >= 0) ? (m_rsel ? 2'b10 : 2'b01) : 2'b00;
            e_wrdy  = m_act && !m_full[m_wsel] && (m_wcnt < m_nv);
            chk("valid", {31'd0, valid_o}, {31'd0, e_valid});
            chk("last", {31'd0, last_o}, {31'd0, e_last});
            chk("vec_done", {31'd0, vdone_o}, {31'd0, e_vdone});
            chk("layer_done", {31'd0, ldone_o}, {31'd0, e_ldone});
            chk("busy", {30'd0, busy_o}, {30'd0, e_busy});
            chk("full", {30'd0, full_o}, {30'd0, m_full});
            chk("wr_sel", {31'd0, wsel_o}, {31'd0, m_wsel});
            chk("wr_ready", {31'd0, wrdy_o}, {31'd0, e_wrdy});
            chk("param_pass", param_o, rdata);
            if (e_valid) chk("addr", {23'd0, addr_o}, 32'(m_word));
            if (e_busy == 2'b00) chk("addr_idle", {23'd0, addr_o}, 32'd0);

            if (valid_o) cnt_valid++;
            if (ldone_o) cnt_ldone++;
            if (vdone_o && ldone_o) cnt_both++;
            if ((full_o == 2'b11) && !wrdy_o) cnt_block++;
            if (vdone_o) begin
                cnt_vdone++;
                rd_hist = {rd_hist[6:0], busy_o[1]};
            end

            if (ls && !m_act) begin
                m_act = 1'b1; m_vec = 0; m_wcnt = 0; m_wsel = 1'b0; m_rsel = 1'b0;
                m_full = 2'b00; m_nv = int'(nv);
            end else begin
                bit [1:0] nf;
                nf = m_full;
                if (m_act && wd && !m_full[m_wsel]) begin
                    nf[m_wsel] = 1'b1;
                    m_wsel = ~m_wsel;
                    m_wcnt++;
                end
                if (m_word < 0) begin
                    if (m_act && m_full[m_rsel]) m_word = 0;
                end else if (m_word < WL) begin
                    if (rdy) m_word++;
                end else begin
                    nf[m_rsel] = 1'b0;
                    m_rsel = ~m_rsel;
                    m_vec++;
                    if (m_vec == m_nv) m_act = 1'b0;
                    m_word = -1;
                end
                m_full = nf;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        cnt_valid = 0; cnt_vdone = 0; cnt_ldone = 0; cnt_both = 0; cnt_block = 0;
        rd_hist = 8'd0;
    endtask

    task automatic start_layer(input int n);
        ls = 1'b1;
        nv = 16'(n);
        tick();
        ls = 1'b0;
    endtask

    task automatic pulse_wd();
        wd = 1'b1;
        tick();
        wd = 1'b0;
    endtask

    // Upstream: wait for wr_ready, spend gap cycles writing, then signal the half complete.
    task automatic fill(input int gap);
        int t;
        t = 0;
        while (!wrdy_o && t < 5000) begin
            tick();
            t++;
        end
        if (!wrdy_o) fail_now("fill_wait");
        repeat (gap) tick();
        pulse_wd();
    endtask

    task automatic wait_layer();
        int t;
        t = 0;
        while (cnt_ldone == 0 && t < 20000) begin
            tick();
            t++;
        end
        if (cnt_ldone == 0) fail_now("layer_wait");
    endtask

    bit tog_stop;

    initial begin
        #1;
        chk("init_full", {30'd0, full_o}, 32'd0);
        chk("init_wrdy", {31'd0, wrdy_o}, 32'd0);
        chk("init_valid", {31'd0, valid_o}, 32'd0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();

        // Single vector
        clr_cnt();
        start_layer(1);
        rdy = 1'b1;
        fill(0);
        chk("t1_full", {30'd0, full_o}, 32'd1);
        chk("t1_busy_pre", {30'd0, busy_o}, 32'd0);
        tick();
        chk("t1_busy", {30'd0, busy_o}, 32'd1);
        chk("t1_first_valid", {31'd0, valid_o}, 32'd1);
        chk("t1_first_addr", {23'd0, addr_o}, 32'd0);
        wait_layer();
        chk("t1_nvalid", 32'(cnt_valid), 32'd288);
        chk("t1_nvdone", 32'(cnt_vdone), 32'd1);
        chk("t1_nldone", 32'(cnt_ldone), 32'd1);
        chk("t1_together", 32'(cnt_both), 32'd1);
        chk("t1_full_end", {30'd0, full_o}, 32'd0);
        chk("t1_wrdy_end", {31'd0, wrdy_o}, 32'd0);

        // Ping-pong, continuous fill
        clr_cnt();
        start_layer(4);
        fork
            begin
                for (int k = 0; k < 4; k++) fill(WL);
            end
            wait_layer();
        join
        chk("t2_nvdone", 32'(cnt_vdone), 32'd4);
        chk("t2_nldone", 32'(cnt_ldone), 32'd1);
        chk("t2_nvalid", 32'(cnt_valid), 32'd1152);
        chk("t2_order", {28'd0, rd_hist[3:0]}, 32'h5);
        chk("t2_blocked_seen", {31'd0, (cnt_block != 0)}, 32'd1);

        // Backpressure
        clr_cnt();
        rdy = 1'b0;
        tog_stop = 1'b0;
        start_layer(1);
        fork
            begin
                fill(0);
                wait_layer();
                tog_stop = 1'b1;
            end
            begin
                while (!tog_stop) begin
                    tick();
                    rdy = ~rdy;
                end
            end
        join
        chk("t3_nvalid", 32'(cnt_valid), 32'd288);
        chk("t3_nvdone", 32'(cnt_vdone), 32'd1);

        // Simultaneous write done on half 1 and release of half 0
        clr_cnt();
        rdy = 1'b1;
        start_layer(2);
        fill(0);
        begin
            int t;
            t = 0;
            while (!last_o && t < 1000) begin
                tick();
                t++;
            end
            if (!last_o) fail_now("t4_last_wait");
        end
        tick();
        wd = 1'b1;
        chk("t4_rel", {31'd0, vdone_o}, 32'd1);
        chk("t4_full_before", {30'd0, full_o}, 32'd1);
        tick();
        wd = 1'b0;
        chk("t4_full_after", {30'd0, full_o}, 32'd2);
        chk("t4_wsel", {31'd0, wsel_o}, 32'd0);
        wait_layer();
        chk("t4_nvdone", 32'(cnt_vdone), 32'd2);

        // Protocol errors: done onto a full half, start while active
        clr_cnt();
        rdy = 1'b0;
        start_layer(4);
        fill(0);
        fill(0);
        chk("t5_full", {30'd0, full_o}, 32'd3);
        pulse_wd();
        chk("t5_full_kept", {30'd0, full_o}, 32'd3);
        chk("t5_wsel_kept", {31'd0, wsel_o}, 32'd0);
        chk("t5_wrdy", {31'd0, wrdy_o}, 32'd0);
        start_layer(1);
        chk("t5_start_ign", {30'd0, full_o}, 32'd3);
        rdy = 1'b1;
        fork
            begin
                fill(0);
                fill(0);
            end
            wait_layer();
        join
        chk("t5_nvdone", 32'(cnt_vdone), 32'd4);
        chk("t5_nldone", 32'(cnt_ldone), 32'd1);

        // Reset mid-read
        clr_cnt();
        start_layer(1);
        fill(0);
        repeat (50) tick();
        chk("t6_reading", {30'd0, busy_o}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_valid", {31'd0, valid_o}, 32'd0);
        chk("t6_busy", {30'd0, busy_o}, 32'd0);
        chk("t6_full", {30'd0, full_o}, 32'd0);
        chk("t6_addr", {23'd0, addr_o}, 32'd0);
        chk("t6_wrdy", {31'd0, wrdy_o}, 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("t6_idle", {31'd0, valid_o}, 32'd0);
        chk("t6_wrdy_after", {31'd0, wrdy_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ip_param_ctrl.md
# ip_param_ctrl

Ping-pong control for the FC weight double buffer: tracks which half is being filled, which is full, and which is being read, and sequences read addresses into the buffer for the inner-product datapath. Sits between the DDR weight stream (upstream), the weight double buffer, and the inner-product MAC array (downstream). One full half holds one weight vector of WL words. Runs a layer of `num_vec_i` vectors per `layer_start_i`.

## Interface
- FW, 32, weight word width (pass-through only; used for the `ip_param_o` width)
- WL, 288, words per weight vector (one buffer half)
- AW, 9, read address width; requires 2^AW >= WL
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  reset; one clock; asynchronous, active-low
- layer_start_i  in  1  one-cycle pulse; loads `num_vec_i`, starts a layer
- num_vec_i  in  16  weight vectors in the layer, sampled on `layer_start_i`; 0 is illegal
- wr_buf_done_i  in  1  from the buffer: current write half complete (1-cycle pulse)
- wr_buf_sel_o  out  1  half being written (0/1)
- wr_ready_o  out  1  the write half is not full and the layer is active; the upstream stream may assert the buffer write enable only while this is high
- param_buf_full_o  out  2  per-half full flags
- param_buf_busy_o  out  2  per-half read-in-progress flags; at most one bit set
- ip_buf_addr_o  out  AW  read address into the busy half
- ip_ready_i  in  1  MAC array accepts a weight this cycle
- ip_param_valid_o  out  1  buffer output is a valid weight this cycle
- ip_last_o  out  1  with valid: last word of the vector
- ip_vec_done_o  out  1  one-cycle pulse: vector released
- layer_done_o  out  1  one-cycle pulse: all `num_vec_i` vectors consumed

## Operation
- Registers: wr_sel, rd_sel, full[1:0], busy[1:0], addr, vec_cnt (16b), wr_cnt (16b), active, state. All reset to 0, state = IDLE.
- `layer_start_i`: active=1, vec_cnt=0, wr_cnt=0, wr_sel=rd_sel=0, full=0. Ignored while active=1.
- Write side: on `wr_buf_done_i`, set full[wr_sel], toggle wr_sel, increment wr_cnt. `wr_ready_o` = active & ~full[wr_sel] & (wr_cnt < num_vec). A `wr_buf_done_i` arriving while full[wr_sel]=1 is a protocol error: ignored, no flag change.
- Read FSM:
  - IDLE: if active & full[rd_sel]: busy[rd_sel]=1, addr=0 -> RD.
  - RD: `ip_param_valid_o` = ip_ready_i; addr advances only on valid. Valid with addr==WL-1: `ip_last_o`=1 -> REL.
  - REL: busy[rd_sel]=0, full[rd_sel]=0, toggle rd_sel, `ip_vec_done_o`=1, vec_cnt+1. If vec_cnt+1==num_vec: `layer_done_o`=1, active=0. -> IDLE.
- `ip_buf_addr_o` = addr while busy, else 0. Address order ascending 0..WL-1.
- Simultaneous set (write done on half A) and clear (REL on half B) in one cycle: both take effect. Both on the same half cannot occur (a full half is never written).

## Timing
- Buffer read is combinational: the weight for `ip_buf_addr_o` is on the buffer output in the same cycle; valid/last are combinational from state, addr, ip_ready_i.
- Full-to-first-valid: full set at edge N; busy and state RD at edge N+1; first valid in cycle N+1 if ip_ready_i=1.
- Vector read: WL accepted cycles; REL adds 1 cycle; next vector (if already full) starts RD one cycle after REL. Steady state: WL+2 cycles per vector with ip_ready_i held high.
- ip_ready_i low in RD: addr, busy frozen; no timeout.
- Reset mid-layer: all flags, counters, and outputs return to 0 asynchronously; the buffer's own write count is reset by the same rstn_i.

## Test plan
- Reset: assert rstn_i mid-RD -> all outputs 0 immediately, state IDLE, wr_ready_o=0.
- Single vector, num_vec=1, WL=288: fill half 0 -> busy=2'b01 next cycle, addrs 0..287 on 288 consecutive valids, ip_last_o at 287, ip_vec_done_o and layer_done_o together, full=0, wr_ready_o=0.
- Ping-pong, num_vec=4, upstream fills continuously: halves alternate 0,1,0,1; wr_ready_o drops when both full; exactly 4 ip_vec_done_o pulses; one layer_done_o.
- Backpressure: toggle ip_ready_i every other cycle -> addr advances only on ready cycles, 288 valids total, no repeated or skipped address.
- Simultaneous: wr_buf_done_i for half 1 in the same cycle as REL of half 0 -> full goes 2'b01 -> 2'b10 in one edge.
- Protocol: layer_start_i while active -> ignored; wr_buf_done_i while full[wr_sel]=1 -> no flag or counter change.
